// File: rtl/serial_pattern_mealy_if.sv
// Serial stream, run-time configuration and match/counter status of the
// pattern detector, grouped into one interface.
interface serial_pattern_mealy_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int FW = $clog2(N);

  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [N-1:0]     cfg_pattern;
  logic             cfg_overlap;
  logic             cnt_clear;
  logic             match;
  logic [FW-1:0]    fill;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clear,
    input  match, fill, match_count, count_sat
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clear,
    output match, fill, match_count, count_sat
  );
endinterface

// File: rtl/serial_pattern_mealy.sv
// Mealy sequence detector for a qualified serial bit stream: run-time pattern
// and overlap mode, combinational match, saturating match counter.
//
// state (fill) | meaning
// 0 .. N-2     | collecting: fewer than N-1 history bits valid
// N-1          | armed: next accepted bit can complete the pattern
module serial_pattern_mealy #(
  parameter int           N           = 4,
  parameter int           CNT_W       = 8,
  parameter logic [N-1:0] PATTERN_RST = 4'b1011,
  parameter bit           OVERLAP_RST = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  serial_pattern_mealy_if.slave bus
);

  localparam int              FW      = $clog2(N);
  localparam int              HW      = N - 1;
  localparam logic [FW-1:0]   ARMED   = FW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [HW-1:0]    hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [N-1:0]     pat_q;
  logic             ovl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             accept;
  logic             match;

  assign accept = bus.in_valid & ~bus.cfg_load;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  // next-state logic
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (bus.cfg_load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bus.in_valid) begin
      hist_d = HW'({hist_q, bus.in_bit});
      if (match) begin
        // overlap keeps the tail of this match as the head of the next one
        fill_d = ovl_q ? ARMED : '0;
      end else if (fill_q != ARMED) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  // Mealy output
  always_comb begin
    match = 1'b0;
    if (accept && (fill_q == ARMED) && ({hist_q, bus.in_bit} == pat_q)) begin
      match = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= PATTERN_RST;
      ovl_q <= OVERLAP_RST;
    end else if (bus.cfg_load) begin
      pat_q <= bus.cfg_pattern;
      ovl_q <= bus.cfg_overlap;
    end
  end

  // clear wins over saturation; a match in the clear cycle still counts once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (bus.cnt_clear) begin
      cnt_q <= match ? CNT_W'(1) : '0;
      sat_q <= 1'b0;
    end else if (match) begin
      if (cnt_q == CNT_MAX) begin
        sat_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.match       = match;
  assign bus.fill        = fill_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;

endmodule
